// File: rtl/apu_pulse_ch.sv
// apu_pulse_ch -- one 2A03-style pulse channel.
//
// It contains the register file ($4000-$4003 or $4004-$4007), the period timer,
// the 8-step duty sequencer, the envelope, the sweep unit and the length counter.
// The APU address decoder selects the channel with `sel`. The APU frame counter
// supplies the quarter-frame and half-frame strobes.
//
// Ports
//   sys_clk        system clock; all state changes on its rising edge
//   sys_n_reset    asynchronous active-low reset
//   sysbus_addr    register index (R0..R3)
//   sysbus_data    bidirectional data bus; driven only while sel & ~we
//   sysbus_we      write strobe
//   sel            channel selected by the address decoder
//   apu_clk        one-cycle timer-enable pulse, once per two CPU cycles
//   qframe         quarter-frame strobe (envelope)
//   hframe         half-frame strobe (length counter, sweep)
//   enable         channel-enable bit from $4015
//   active         registered (length counter != 0)
//   out            registered sample to the mixer
module apu_pulse_ch #(
  parameter int CHANNEL = 0,
  parameter int TIMER_N = 11,
  parameter int OUT_N   = 4,
  parameter int DATA_N  = 8
) (
  input  logic               sys_clk,
  input  logic               sys_n_reset,
  input  logic [1:0]         sysbus_addr,
  inout  wire  [DATA_N-1:0]  sysbus_data,
  input  logic               sysbus_we,
  input  logic               sel,
  input  logic               apu_clk,
  input  logic               qframe,
  input  logic               hframe,
  input  logic               enable,
  output logic               active,
  output logic [OUT_N-1:0]   out
);

  localparam int TW = TIMER_N + 1;

  // register fields
  logic [1:0]         duty_q, duty_d;
  logic               halt_q, halt_d;
  logic               const_q, const_d;
  logic [3:0]         vol_q, vol_d;
  logic               sw_en_q, sw_en_d;
  logic [2:0]         sw_per_q, sw_per_d;
  logic               sw_neg_q, sw_neg_d;
  logic [2:0]         sw_sh_q, sw_sh_d;
  logic [TIMER_N-1:0] period_q, period_d;
  logic [4:0]         len_idx_q, len_idx_d;

  // channel state
  logic [TIMER_N-1:0] timer_q, timer_d;
  logic [2:0]         step_q, step_d;
  logic               env_start_q, env_start_d;
  logic [3:0]         decay_q, decay_d;
  logic [3:0]         ediv_q, ediv_d;
  logic [2:0]         sdiv_q, sdiv_d;
  logic               sweep_reload_q, sweep_reload_d;
  logic [7:0]         len_q, len_d;
  logic               active_q, active_d;
  logic [OUT_N-1:0]   out_q, out_d;

  logic               wr_en, rd_en;
  logic [DATA_N-1:0]  wdata, rdata;

  function automatic logic [7:0] len_lookup(input logic [4:0] idx);
    logic [7:0] v;
    case (idx)
      5'd0:  v = 8'd10;   5'd1:  v = 8'd254;  5'd2:  v = 8'd20;   5'd3:  v = 8'd2;
      5'd4:  v = 8'd40;   5'd5:  v = 8'd4;    5'd6:  v = 8'd80;   5'd7:  v = 8'd6;
      5'd8:  v = 8'd160;  5'd9:  v = 8'd8;    5'd10: v = 8'd60;   5'd11: v = 8'd10;
      5'd12: v = 8'd14;   5'd13: v = 8'd12;   5'd14: v = 8'd26;   5'd15: v = 8'd14;
      5'd16: v = 8'd12;   5'd17: v = 8'd16;   5'd18: v = 8'd24;   5'd19: v = 8'd18;
      5'd20: v = 8'd48;   5'd21: v = 8'd20;   5'd22: v = 8'd96;   5'd23: v = 8'd22;
      5'd24: v = 8'd192;  5'd25: v = 8'd24;   5'd26: v = 8'd72;   5'd27: v = 8'd26;
      5'd28: v = 8'd16;   5'd29: v = 8'd28;   5'd30: v = 8'd32;   default: v = 8'd30;
    endcase
    return v;
  endfunction

  // In each pattern, bit n is the output level at step n.
  function automatic logic duty_bit(input logic [1:0] d, input logic [2:0] s);
    logic [7:0] p;
    case (d)
      2'd0:    p = 8'b0000_0010;
      2'd1:    p = 8'b0000_0110;
      2'd2:    p = 8'b0001_1110;
      default: p = 8'b1111_1001;
    endcase
    return p[s];
  endfunction

  // Sweep target. The channel-0 subtract uses ones' complement, so it takes one
  // more off the result. A borrow out of the extra top bit means the result is
  // negative, and that clamps the target to 0.
  logic [TIMER_N-1:0] delta;
  logic [TW-1:0]      sum;
  logic [TW:0]        diff;
  logic [TW-1:0]      target;
  logic               neg_bias;
  logic               mute;

  always_comb begin
    neg_bias = (CHANNEL == 0) ? 1'b1 : 1'b0;
    delta    = period_q >> sw_sh_q;
    sum      = {1'b0, period_q} + {1'b0, delta};
    diff     = {2'b00, period_q} - {2'b00, delta} - {{TW{1'b0}}, neg_bias};
    if (sw_neg_q) target = diff[TW] ? '0 : diff[TW-1:0];
    else          target = sum;
    mute = (period_q < TIMER_N'(8)) | (~sw_neg_q & target[TIMER_N]);
  end

  assign wr_en = sel & sysbus_we;
  assign rd_en = sel & ~sysbus_we;
  assign wdata = sysbus_data;

  always_comb begin
    case (sysbus_addr)
      2'd0:    rdata = {duty_q, halt_q, const_q, vol_q};
      2'd1:    rdata = {sw_en_q, sw_per_q, sw_neg_q, sw_sh_q};
      2'd2:    rdata = period_q[7:0];
      default: rdata = {len_idx_q, period_q[TIMER_N-1:8]};
    endcase
  end

  assign sysbus_data = rd_en ? rdata : 'z;

  always_comb begin
    duty_d         = duty_q;
    halt_d         = halt_q;
    const_d        = const_q;
    vol_d          = vol_q;
    sw_en_d        = sw_en_q;
    sw_per_d       = sw_per_q;
    sw_neg_d       = sw_neg_q;
    sw_sh_d        = sw_sh_q;
    period_d       = period_q;
    len_idx_d      = len_idx_q;
    timer_d        = timer_q;
    step_d         = step_q;
    env_start_d    = env_start_q;
    decay_d        = decay_q;
    ediv_d         = ediv_q;
    sdiv_d         = sdiv_q;
    sweep_reload_d = sweep_reload_q;
    len_d          = len_q;

    if (apu_clk) begin
      if (timer_q == '0) begin
        timer_d = period_q;
        step_d  = step_q - 3'd1;
      end else begin
        timer_d = timer_q - TIMER_N'(1);
      end
    end

    if (qframe) begin
      if (env_start_q) begin
        env_start_d = 1'b0;
        decay_d     = 4'd15;
        ediv_d      = vol_q;
      end else if (ediv_q == 4'd0) begin
        ediv_d = vol_q;
        if (decay_q != 4'd0) decay_d = decay_q - 4'd1;
        else if (halt_q)     decay_d = 4'd15;
      end else begin
        ediv_d = ediv_q - 4'd1;
      end
    end

    if (hframe) begin
      if (sdiv_q == 3'd0 && sw_en_q && sw_sh_q != 3'd0 && !mute)
        period_d = target[TIMER_N-1:0];
      if (sdiv_q == 3'd0 || sweep_reload_q) begin
        sdiv_d         = sw_per_q;
        sweep_reload_d = 1'b0;
      end else begin
        sdiv_d = sdiv_q - 3'd1;
      end
      if (!halt_q && len_q != 8'd0) len_d = len_q - 8'd1;
    end

    // Bus writes are applied after the strobe updates, so a write always beats
    // the sweep update, the length decrement and the envelope start.
    if (wr_en) begin
      case (sysbus_addr)
        2'd0: {duty_d, halt_d, const_d, vol_d} = wdata;
        2'd1: begin
          {sw_en_d, sw_per_d, sw_neg_d, sw_sh_d} = wdata;
          sweep_reload_d = 1'b1;
        end
        2'd2: period_d[7:0] = wdata;
        default: begin
          len_idx_d                  = wdata[7:3];
          period_d[TIMER_N-1:8]      = wdata[2:0];
          step_d                     = 3'd0;
          env_start_d                = 1'b1;
          if (enable) len_d          = len_lookup(wdata[7:3]);
        end
      endcase
    end

    if (!enable) len_d = 8'd0;
  end

  always_comb begin
    active_d = (len_q != 8'd0);
    if (mute || len_q == 8'd0 || !duty_bit(duty_q, step_q)) out_d = '0;
    else if (const_q)                                          out_d = OUT_N'(vol_q);
    else                                                       out_d = OUT_N'(decay_q);
  end

  always_ff @(posedge sys_clk or negedge sys_n_reset) begin
    if (!sys_n_reset) begin
      duty_q         <= '0;
      halt_q         <= 1'b0;
      const_q        <= 1'b0;
      vol_q          <= '0;
      sw_en_q        <= 1'b0;
      sw_per_q       <= '0;
      sw_neg_q       <= 1'b0;
      sw_sh_q        <= '0;
      period_q       <= '0;
      len_idx_q      <= '0;
      timer_q        <= '0;
      step_q         <= '0;
      env_start_q    <= 1'b0;
      decay_q        <= '0;
      ediv_q         <= '0;
      sdiv_q         <= '0;
      sweep_reload_q <= 1'b0;
      len_q          <= '0;
      active_q       <= 1'b0;
      out_q          <= '0;
    end else begin
      duty_q         <= duty_d;
      halt_q         <= halt_d;
      const_q        <= const_d;
      vol_q          <= vol_d;
      sw_en_q        <= sw_en_d;
      sw_per_q       <= sw_per_d;
      sw_neg_q       <= sw_neg_d;
      sw_sh_q        <= sw_sh_d;
      period_q       <= period_d;
      len_idx_q      <= len_idx_d;
      timer_q        <= timer_d;
      step_q         <= step_d;
      env_start_q    <= env_start_d;
      decay_q        <= decay_d;
      ediv_q         <= ediv_d;
      sdiv_q         <= sdiv_d;
      sweep_reload_q <= sweep_reload_d;
      len_q          <= len_d;
      active_q       <= active_d;
      out_q          <= out_d;
    end
  end

  assign active = active_q;
  assign out    = out_q;

endmodule

// File: tb/tb_apu_pulse_ch.sv
// Scoreboard bench for apu_pulse_ch. There are two instances: channel 0 and channel 1.
// Both share stimulus. Each has its own data bus.
module tb_apu_pulse_ch;

  localparam int K_OUT0  = 0;
  localparam int K_ACT0  = 1;
  localparam int K_DATA0 = 2;
  localparam int K_DATA1 = 3;

  typedef struct {
    int         kind;
    logic [7:0] exp;
    string      name;
  } sb_item_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] addr;
  logic       we;
  logic       sel;
  logic       apu_clk;
  logic       qframe;
  logic       hframe;
  logic       enable;
  logic [7:0] drv_val;
  logic       drv_en;
  wire  [7:0] data0;
  wire  [7:0] data1;
  logic       active0, active1;
  logic [3:0] out0, out1;

  sb_item_t sb[$];
  event     sb_ev;
  int       checks;
  int       failures;

  assign data0 = drv_en ? drv_val : 8'hzz;
  assign data1 = drv_en ? drv_val : 8'hzz;

  apu_pulse_ch #(.CHANNEL(0)) u0 (
    .sys_clk(clk), .sys_n_reset(rst_n), .sysbus_addr(addr), .sysbus_data(data0),
    .sysbus_we(we), .sel(sel), .apu_clk(apu_clk), .qframe(qframe), .hframe(hframe),
    .enable(enable), .active(active0), .out(out0)
  );

  apu_pulse_ch #(.CHANNEL(1)) u1 (
    .sys_clk(clk), .sys_n_reset(rst_n), .sysbus_addr(addr), .sysbus_data(data1),
    .sysbus_we(we), .sel(sel), .apu_clk(apu_clk), .qframe(qframe), .hframe(hframe),
    .enable(enable), .active(active1), .out(out1)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // monitor: pops each expectation and compares against the DUT as it stands now
  initial begin
    sb_item_t   it;
    logic [7:0] act;
    forever begin
      @(sb_ev);
      while (sb.size() > 0) begin
        it = sb.pop_front();
        case (it.kind)
          K_OUT0:  act = {4'h0, out0};
          K_ACT0:  act = {7'h0, active0};
          K_DATA0: act = data0;
          default: act = data1;
        endcase
        checks++;
        if (act !== it.exp) begin
          failures++;
          $display("FAIL %s: got %02h expected %02h", it.name, act, it.exp);
        end
      end
    end
  end

  task automatic expect_val(input int kind, input logic [7:0] exp, input string name);
    sb_item_t it;
    it.kind = kind;
    it.exp  = exp;
    it.name = name;
    sb.push_back(it);
    -> sb_ev;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] v);
    sel = 1'b1; we = 1'b1; addr = a; drv_val = v; drv_en = 1'b1;
    tick();
    sel = 1'b0; we = 1'b0; drv_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] e0, input logic [7:0] e1,
                    input string name);
    sel = 1'b1; we = 1'b0; addr = a;
    #1;
    expect_val(K_DATA0, e0, {name, "_ch0"});
    expect_val(K_DATA1, e1, {name, "_ch1"});
    sel = 1'b0;
  endtask

  task automatic settle();
    tick();
    tick();
  endtask

  task automatic pulse_q();
    qframe = 1'b1; tick(); qframe = 1'b0; tick();
  endtask

  task automatic pulse_h();
    hframe = 1'b1; tick(); hframe = 1'b0; settle();
  endtask

  initial begin
    logic [7:0] duty2;
    int         m_timer;
    int         m_step;
    logic [7:0] e;

    checks = 0; failures = 0;
    rst_n = 1'b0; addr = 2'd0; we = 1'b0; sel = 1'b0; apu_clk = 1'b0;
    qframe = 1'b0; hframe = 1'b0; enable = 1'b0; drv_val = 8'h00; drv_en = 1'b0;
    duty2 = 8'b0001_1110;

    tick(); tick();
    rst_n = 1'b1;
    settle();

    // reset state
    rd(2'd0, 8'h00, 8'h00, "rst_r0");
    rd(2'd1, 8'h00, 8'h00, "rst_r1");
    rd(2'd2, 8'h00, 8'h00, "rst_r2");
    rd(2'd3, 8'h00, 8'h00, "rst_r3");
    expect_val(K_OUT0, 8'h00, "rst_out");
    expect_val(K_ACT0, 8'h00, "rst_active");

    // duty/timer: duty 2, halt, const vol 15, period 16, len 254
    enable = 1'b1;
    wr(2'd0, 8'hBF);
    wr(2'd2, 8'h10);
    wr(2'd3, 8'h08);
    settle();
    expect_val(K_ACT0, 8'h01, "len254_active");
    rd(2'd0, 8'hBF, 8'hBF, "r0_readback");
    rd(2'd3, 8'h08, 8'h08, "r3_readback");
    m_timer = 0;
    m_step  = 0;
    for (int i = 0; i < 136; i++) begin
      apu_clk = 1'b1; tick(); apu_clk = 1'b0; tick();
      if (m_timer == 0) begin
        m_timer = 16;
        m_step  = (m_step + 7) % 8;
      end else begin
        m_timer = m_timer - 1;
      end
      expect_val(K_OUT0, duty2[m_step] ? 8'h0F : 8'h00, "duty2_seq");
    end

    // envelope: duty 3 (step 0 high), no loop, vol 3
    wr(2'd0, 8'hC3);
    wr(2'd3, 8'h08);
    settle();
    expect_val(K_OUT0, 8'h00, "env_before_start");
    for (int q = 1; q <= 64; q++) begin
      pulse_q();
      if (q == 1)  expect_val(K_OUT0, 8'h0F, "env_q1");
      if (q == 5)  expect_val(K_OUT0, 8'h0E, "env_q5");
      if (q == 60) expect_val(K_OUT0, 8'h01, "env_q60");
      if (q == 61) expect_val(K_OUT0, 8'h00, "env_q61");
    end
    expect_val(K_OUT0, 8'h00, "env_q64_hold");
    wr(2'd0, 8'hE3);
    pulse_q();
    expect_val(K_OUT0, 8'h0F, "env_loop_wrap");

    // length counter: const vol 3, no halt, len 2
    wr(2'd0, 8'hD3);
    wr(2'd3, 8'h18);
    settle();
    expect_val(K_ACT0, 8'h01, "len2_active");
    expect_val(K_OUT0, 8'h03, "len2_out");
    pulse_h();
    expect_val(K_ACT0, 8'h01, "len1_active");
    pulse_h();
    expect_val(K_ACT0, 8'h00, "len0_active");
    expect_val(K_OUT0, 8'h00, "len0_out");
    enable = 1'b0;
    wr(2'd3, 8'h08);
    settle();
    expect_val(K_ACT0, 8'h00, "disabled_no_load");
    enable = 1'b1;

    // sweep subtract: period 0x100, shift 1
    wr(2'd2, 8'h00);
    wr(2'd3, 8'h09);
    wr(2'd1, 8'h89);
    pulse_h();
    rd(2'd2, 8'h7F, 8'h80, "sweep_neg_r2");
    rd(2'd3, 8'h08, 8'h08, "sweep_neg_r3");

    // low-period mute boundary
    wr(2'd2, 8'h07);
    settle();
    expect_val(K_OUT0, 8'h00, "period7_mute");
    wr(2'd2, 8'h08);
    settle();
    expect_val(K_OUT0, 8'h03, "period8_audible");

    // sweep add without overflow
    wr(2'd1, 8'h81);
    wr(2'd2, 8'h00);
    wr(2'd3, 8'h09);
    pulse_h();
    rd(2'd2, 8'h80, 8'h80, "sweep_add_r2");
    rd(2'd3, 8'h09, 8'h09, "sweep_add_r3");

    // sweep add with overflow: muted and period held
    wr(2'd2, 8'h00);
    wr(2'd3, 8'h0E);
    settle();
    expect_val(K_OUT0, 8'h00, "overflow_mute");
    pulse_h();
    rd(2'd2, 8'h00, 8'h00, "overflow_hold_r2");
    rd(2'd3, 8'h0E, 8'h0E, "overflow_hold_r3");

    // R3 load coincident with hframe: the load wins
    hframe = 1'b1;
    wr(2'd3, 8'h18);
    hframe = 1'b0;
    settle();
    expect_val(K_ACT0, 8'h01, "coincident_load");
    pulse_h();
    expect_val(K_ACT0, 8'h01, "coincident_len1");
    pulse_h();
    expect_val(K_ACT0, 8'h00, "coincident_len0");

    // asynchronous reset mid-operation
    wr(2'd2, 8'h10);
    wr(2'd3, 8'h08);
    settle();
    e = 8'h03;
    expect_val(K_OUT0, e, "pre_reset_out");
    #3;
    rst_n = 1'b0;
    #1;
    expect_val(K_OUT0, 8'h00, "async_rst_out");
    expect_val(K_ACT0, 8'h00, "async_rst_active");
    tick();
    rst_n = 1'b1;
    settle();
    rd(2'd0, 8'h00, 8'h00, "post_rst_r0");
    rd(2'd2, 8'h00, 8'h00, "post_rst_r2");

    #5;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apu_pulse_ch.md
Name: apu_pulse_ch

Overview:
- Full 2A03-style pulse channel: register file plus timer, 8-step duty sequencer, envelope, sweep unit and length counter.
- One instance per pulse channel inside the APU, selected by the APU address decoder at $4000-$4003 / $4004-$4007.
- Frame-sequencer strobes come from the APU frame counter.
- The 4-bit output feeds the APU mixer.

Parameters:
CHANNEL, 0, sweep negate mode: 0 = ones' complement (pulse 1), 1 = two's complement (pulse 2)
TIMER_N, 11, timer/period width
OUT_N, 4, output sample width

Ports:
sys.clk  input  1  system clock, sys_if member; all state on rising edge
sys.n_reset  input  1  reset, sys_if member; asynchronous, active-low
sysbus.addr  input  2 (LSBs used)  register index
sysbus.data  inout  `DATA_N (8)  bus data; driven only on read, otherwise 'z
sysbus.we  input  1  write strobe
sel  input  1  channel selected by decoder
apu_clk  input  1  1-cycle timer-enable pulse, once per 2 CPU cycles
qframe  input  1  quarter-frame strobe (envelope)
hframe  input  1  half-frame strobe (length, sweep)
enable  input  1  $4015 channel-enable bit
active  output  1  length counter != 0
out  output  OUT_N  sample

Behaviour:
- Reset: all regs, timer, step, envelope, sweep and length state = 0; out = 0; active = 0; sysbus.data = 'z.
- Registers are written when sel & we and read back when sel & ~we, combinationally, as stored values.
  - R0: duty[7:6], halt/loop[5], const[4], vol[3:0].
  - R1: sw_en[7], sw_per[6:4], sw_neg[3], sw_sh[2:0]. A write sets sweep_reload.
  - R2: period[7:0].
  - R3: len_idx[7:3], period[10:8]. A write also does the following: step <= 0; env_start <= 1; if enable, len <= LEN_TABLE[len_idx].
- LEN_TABLE: 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
- Timer, on apu_clk:
  - If timer == 0: timer <= period; step <= step - 1 (mod 8, wraps 0 -> 7).
  - Else: timer decrements.
  - Period writes do not reload the timer.
- Duty patterns (bit at step 0..7):
  - d0 = 0,1,0,0,0,0,0,0
  - d1 = 0,1,1,0,0,0,0,0
  - d2 = 0,1,1,1,1,0,0,0
  - d3 = 1,0,0,1,1,1,1,1
- Envelope, on qframe:
  - If env_start: env_start <= 0; decay <= 15; ediv <= vol.
  - Else if ediv == 0: ediv <= vol; if decay != 0, decay decrements; else if loop, decay <= 15.
  - Else: ediv decrements.
- Sweep target (combinational, TIMER_N+1 bits):
  - delta = period >> sw_sh.
  - sw_neg = 0: target = period + delta.
  - sw_neg = 1, CHANNEL 0: target = period - delta - 1.
  - sw_neg = 1, CHANNEL 1: target = period - delta.
  - Negative results clamp to 0.
- mute = (period < 8) | (~sw_neg & target > 11'h7FF). mute applies regardless of sw_en.
- Sweep, on hframe:
  - If sdiv == 0 & sw_en & sw_sh != 0 & ~mute: period <= target[10:0].
  - Then, if sdiv == 0 | sweep_reload: sdiv <= sw_per and sweep_reload <= 0; else sdiv decrements.
- Length counter, on hframe: if ~halt & len != 0, len decrements.
  - enable = 0 forces len <= 0 every cycle; R3 writes then do not load.
- active = (len != 0), registered.
- out = 0 if mute, len == 0, or duty bit == 0; otherwise const ? vol : decay. out is registered, 1-cycle latency from state.
- Simultaneous events:
  - R3 write and hframe in the same cycle: the load wins over the decrement.
  - R2/R3 write and a sweep period update in the same cycle: the bus write wins.
  - R3 write and qframe in the same cycle: env_start is set, and the envelope's start processing happens on the next qframe.
  - R1 write and hframe in the same cycle: sweep_reload is set for the next hframe.
- Async reset mid-operation clears everything immediately; no bus drive during reset.

Test Plan:
- Reset then read R0-R3 -> all 8'h00; out = 0, active = 0; data = 'z when sel = 0.
- enable = 1; R0 = 8'hBF (duty 2, halt, const, vol 15); R2 = 8'h10; R3 = 8'h08 -> len = 254, active = 1. Over 8*17 apu_clk pulses, out = 15 for exactly 4 of 8 steps, period 136 apu_clk.
- R0 = 8'h03 (envelope, no loop, vol 3); R3 write; 64 qframe pulses -> decay reaches 0 after 1 + 15*4 qframes and stays 0. With R0 = 8'h23 (loop), decay wraps to 15.
- R3 = 8'h18 (len 2), halt = 0; two hframe -> active drops to 0 and out = 0. With enable = 0, an R3 write leaves len = 0.
- period = 8'h100, R1 = 8'h89 (en, per 0, neg, sh 1); one hframe -> CHANNEL 0 gives period 8'h07F, CHANNEL 1 gives 8'h080. period = 7 -> out = 0.
- period = 11'h600, R1 = 8'h81 (add, sh 1) -> target 11'h900 > 7FF: muted, period unchanged on hframe. Also: R3 write coincident with hframe -> len = table value.
